lcd_nibble_driver: RTL and testbench
====================================

// Module: lcd_nibble_driver
// PURPOSE
//  Sits between the CPU lcd output stream and the HD44780 pins (lcd_data, lcd_e, lcd_rs).
//  Converts each CPU word into one byte (two 4-bit nibbles) or a single nibble on the HD44780 bus.
//  Generates all setup, enable-pulse and execution timing in hardware; the CPU no longer bit-bangs.
//  Runs in the 50 MHz CPU clock domain.
// PARAMETERS
//  T_SETUP      2      cycles RS/data stable before E rises (>=40 ns)
//  T_E_HIGH     25     cycles E held high (>=450 ns)
//  T_E_LOW      25     cycles E low between the two nibbles of a byte
//  T_EXEC       2000   cycles wait after a normal byte (40 us)
//  T_LONG       80000  cycles wait after clear (0x01) or home (0x02/0x03) with rs=0
//  T_POWERUP    2000000 cycles power-on wait; LCD_POWERUP_INIT_EN builds only
// PORTS
//  clk          in   1   CPU clock, 50 MHz
//  rst          in   1   asynchronous, active-high reset
//  in1          in   32  [7:0] byte, [8] rs, [9] nibble_only (send [7:4] only), [31:10] ignored
//  in1_stb      in   1   word valid
//  in1_ack      out  1   one-cycle pulse, word accepted
//  lcd_data     out  4   HD44780 DB7..DB4
//  lcd_e        out  1   HD44780 enable
//  lcd_rs       out  1   HD44780 register select
//  busy         out  1   high whenever the FSM is not IDLE
// BEHAVIOUR
//  Reset: lcd_data=0, lcd_e=0, lcd_rs=0, in1_ack=0; busy=0 (busy=1 with LCD_POWERUP_INIT_EN).
//  Reset mid-operation aborts immediately. E drops asynchronously, with no partial-cycle hold.
//  Handshake:
//   - In IDLE with in1_stb=1: latch the word, pulse in1_ack for exactly that cycle, go to SETUP_H.
//   - Outside IDLE, in1_ack=0 and in1 is not sampled. A held stb is accepted again on the first IDLE cycle.
//   - Max throughput is one word per (setup + pulses + wait) period.
//  FSM (one down-counter, cnt):
//   - IDLE
//   - SETUP_H (T_SETUP): lcd_rs=rs, lcd_data=byte[7:4]
//   - EHI_H (T_E_HIGH): lcd_e=1
//   - ELO_H (T_E_LOW): lcd_e=0
//   - SETUP_L (T_SETUP): lcd_data=byte[3:0]
//   - EHI_L (T_E_HIGH): lcd_e=1
//   - WAIT (T_EXEC or T_LONG)
//   - Back to IDLE.
//   - nibble_only=1: go ELO_H -> WAIT and skip the low nibble; WAIT uses T_EXEC.
//  Timing rules:
//   - Each state lasts exactly its parameter in cycles. cnt loads P-1 on entry and the state exits when cnt==0.
//   - lcd_data/lcd_rs change only while lcd_e=0. They hold their last value in IDLE (not cleared).
//   - T_LONG is selected when rs==0, nibble_only==0 and byte[7:2]==0 and byte!=0 (codes 0x01..0x03).
//   - Otherwise T_EXEC. byte 0x00 with rs=0 uses T_EXEC.
//  Counter width is $clog2 of the largest enabled parameter. A parameter of 0 is illegal; min is 1.
// CONFIGURATION
//  LCD_POWERUP_INIT_EN defined:
//   - After reset, wait T_POWERUP cycles, then replay an internal ROM through the same FSM.
//   - ROM: nibbles 0x3,0x3,0x3,0x2 (nibble_only, rs=0), then bytes 0x28,0x0C,0x01,0x06 (rs=0).
//   - busy=1 and in1_ack=0 until the ROM completes; then enter IDLE.
//  Undefined:
//   - No power-up wait or ROM. IDLE directly after reset.
//   - The CPU sends the init sequence itself, using the nibble_only flag.
// STRUCTURE
//  Package lcd_pkg:
//   - state enum
//   - in1 bit positions (LCD_RS_BIT=8, LCD_NIB_BIT=9)
//   - HD44780 command constants (CLEAR=8'h01, HOME=8'h02, FUNC_4BIT=8'h28, DISP_ON=8'h0C, ENTRY=8'h06)
//   - init ROM contents
//  Sub-module lcd_timer: loadable down-counter with load/value/done. Instantiated once.
//  Top level becomes: lcd_stb/lcd_ack/lcd_bus -> in1_stb/in1_ack/in1. The lcd register block is removed.
// TESTING (sim parameters: T_SETUP=2, T_E_HIGH=3, T_E_LOW=3, T_EXEC=10, T_LONG=40, T_POWERUP=20)
//  1. Write 0x1_48 ('H', rs=1):
//     - in1_ack pulses once.
//     - rs=1 and data=4 for 2 cycles, then E high for 3 cycles.
//     - E low 3, then data=8 for 2, then E high 3.
//     - WAIT 10 cycles, then busy=0.
//  2. Write 0x2_30 (nibble_only):
//     - Exactly one E pulse with data=3.
//     - Then 10 wait cycles.
//     - Total busy = 2+3+3+10 = 18 cycles.
//  3. Write 0x001 (clear): WAIT lasts 40 cycles. Write 0x000: WAIT lasts 10 cycles.
//  4. Hold stb high with three words queued back to back:
//     - Exactly 3 in1_ack pulses, each on the first IDLE cycle.
//     - No word is dropped or duplicated.
//     - lcd_data never changes while E=1 (assertion).
//  5. Assert rst during EHI_L:
//     - lcd_e=0 in the same cycle; all outputs reach reset values.
//     - After release, the next word is sent correctly.
//  6. LCD_POWERUP_INIT_EN defined:
//     - No E pulse for 20 cycles after reset.
//     - Then E-pulse nibbles 3,3,3,2,2,8,0,C,0,1,0,6.
//     - The 0x01 is followed by a 40-cycle wait.
//     - stb held during init gets no ack until busy falls.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit nibble driver.
// The init ROM is only replayed in LCD_POWERUP_INIT_EN builds.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWR,
        ST_SETUP_H,
        ST_EHI_H,
        ST_ELO_H,
        ST_SETUP_L,
        ST_EHI_L,
        ST_WAIT
    } lcd_state_t;

    localparam int LCD_RS_BIT  = 8;
    localparam int LCD_NIB_BIT = 9;

    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] HOME      = 8'h02;
    localparam logic [7:0] FUNC_4BIT = 8'h28;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] ENTRY     = 8'h06;

    localparam int INIT_LEN = 8;

    // ROM word layout matches in1[9:0]: {nibble_only, rs, byte}
    function automatic logic [9:0] init_word(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return {1'b1, 1'b0, 8'h30};
            3'd3:             return {1'b1, 1'b0, 8'h20};
            3'd4:             return {1'b0, 1'b0, FUNC_4BIT};
            3'd5:             return {1'b0, 1'b0, DISP_ON};
            3'd6:             return {1'b0, 1'b0, CLEAR};
            default:          return {1'b0, 1'b0, ENTRY};
        endcase
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that times every FSM state; done while the count is zero.
module lcd_timer #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign value = cnt;
    assign done  = (cnt == '0);

endmodule

// File: rtl/lcd_nibble_driver.sv
// Converts CPU words into timed HD44780 4-bit bus cycles (lcd_data/lcd_e/lcd_rs).
// Define LCD_POWERUP_INIT_EN to add the power-up wait and init ROM replay after reset.
module lcd_nibble_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP   = 2,
    parameter int T_E_HIGH  = 25,
    parameter int T_E_LOW   = 25,
    parameter int T_EXEC    = 2000,
    parameter int T_LONG    = 80000,
    parameter int T_POWERUP = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in1,
    input  logic        in1_stb,
    output logic        in1_ack,
    output logic [3:0]  lcd_data,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        busy
);

    localparam int T_MAX_BUS = imax(imax(imax(T_SETUP, T_E_HIGH), imax(T_E_LOW, T_EXEC)), T_LONG);
`ifdef LCD_POWERUP_INIT_EN
    localparam int T_MAX = imax(T_MAX_BUS, T_POWERUP);
`else
    localparam int T_MAX = T_MAX_BUS;
    localparam int t_powerup_unused = T_POWERUP;
`endif
    localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

`ifdef LCD_POWERUP_INIT_EN
    localparam lcd_state_t       RST_STATE = ST_PWR;
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(T_POWERUP - 1);
`else
    localparam lcd_state_t       RST_STATE = ST_IDLE;
    localparam logic [CNT_W-1:0] CNT_RST   = '0;
`endif

    lcd_state_t       state;
    lcd_state_t       nxt;
    logic [9:0]       word;
    logic [9:0]       start_word;
    logic             start;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt_value_unused;
    logic             done;
    logic             in1_hi_unused;

`ifdef LCD_POWERUP_INIT_EN
    logic             init_active;
    logic [2:0]       rom_idx;
`endif

    assign in1_hi_unused = ^in1[31:10];

    // Clear and home need the long execution wait; 0x00 does not
    function automatic logic [CNT_W-1:0] wait_len(input logic [9:0] w);
        if (!w[LCD_RS_BIT] && !w[LCD_NIB_BIT] && (w[7:2] == 6'd0) && (w[7:0] != 8'd0))
            return CNT_W'(T_LONG - 1);
        return CNT_W'(T_EXEC - 1);
    endfunction

    lcd_timer #(
        .W       (CNT_W),
        .RST_VAL (CNT_RST)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .value    (cnt_value_unused),
        .done     (done)
    );

    always_comb begin
        nxt        = state;
        start      = 1'b0;
        start_word = in1[9:0];
        load       = 1'b0;
        load_val   = '0;
        case (state)
            ST_IDLE: start = in1_stb;
            ST_PWR: begin
                if (done) begin
                    start      = 1'b1;
                    start_word = init_word(3'd0);
                end
            end
            ST_SETUP_H: if (done) begin nxt = ST_EHI_H; load = 1'b1; load_val = CNT_W'(T_E_HIGH - 1); end
            ST_EHI_H:   if (done) begin nxt = ST_ELO_H; load = 1'b1; load_val = CNT_W'(T_E_LOW - 1); end
            ST_ELO_H: begin
                if (done) begin
                    load = 1'b1;
                    if (word[LCD_NIB_BIT]) begin
                        nxt      = ST_WAIT;
                        load_val = wait_len(word);
                    end else begin
                        nxt      = ST_SETUP_L;
                        load_val = CNT_W'(T_SETUP - 1);
                    end
                end
            end
            ST_SETUP_L: if (done) begin nxt = ST_EHI_L; load = 1'b1; load_val = CNT_W'(T_E_HIGH - 1); end
            ST_EHI_L:   if (done) begin nxt = ST_WAIT;  load = 1'b1; load_val = wait_len(word); end
            ST_WAIT: begin
                if (done) begin
                    nxt = ST_IDLE;
`ifdef LCD_POWERUP_INIT_EN
                    if (init_active && (rom_idx != 3'(INIT_LEN - 1))) begin
                        start      = 1'b1;
                        start_word = init_word(rom_idx + 3'd1);
                    end
`endif
                end
            end
            default: nxt = ST_IDLE;
        endcase
        if (start) begin
            nxt      = ST_SETUP_H;
            load     = 1'b1;
            load_val = CNT_W'(T_SETUP - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) word <= start_word;
    end

    // Bus outputs are registered; data/rs only move on transitions where E is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RST_STATE;
            lcd_e    <= 1'b0;
            lcd_data <= 4'd0;
            lcd_rs   <= 1'b0;
`ifdef LCD_POWERUP_INIT_EN
            init_active <= 1'b1;
            rom_idx     <= 3'd0;
`endif
        end else begin
            state <= nxt;
            lcd_e <= (nxt == ST_EHI_H) || (nxt == ST_EHI_L);
            if (start) begin
                lcd_rs   <= start_word[LCD_RS_BIT];
                lcd_data <= start_word[7:4];
            end else if ((state == ST_ELO_H) && (nxt == ST_SETUP_L)) begin
                lcd_data <= word[3:0];
            end
`ifdef LCD_POWERUP_INIT_EN
            if (start && (state == ST_WAIT)) rom_idx <= rom_idx + 3'd1;
            if ((state == ST_WAIT) && (nxt == ST_IDLE)) init_active <= 1'b0;
`endif
        end
    end

    assign in1_ack = (state == ST_IDLE) && in1_stb && !rst;
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_nibble_driver.sv
// Scoreboard bench for lcd_nibble_driver: stimulus pushes expected nibbles, a bus monitor checks them.
module tb_lcd_nibble_driver;

    localparam int T_SETUP   = 2;
    localparam int T_E_HIGH  = 3;
    localparam int T_E_LOW   = 3;
    localparam int T_EXEC    = 10;
    localparam int T_LONG    = 40;
    localparam int T_POWERUP = 20;
    localparam int BOUND     = 5000;
`ifdef LCD_POWERUP_INIT_EN
    localparam int RST_BUSY = 1;
`else
    localparam int RST_BUSY = 0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] in1;
    logic        in1_stb;
    logic        in1_ack;
    logic [3:0]  lcd_data;
    logic        lcd_e;
    logic        lcd_rs;
    logic        busy;

    lcd_nibble_driver #(
        .T_SETUP   (T_SETUP),
        .T_E_HIGH  (T_E_HIGH),
        .T_E_LOW   (T_E_LOW),
        .T_EXEC    (T_EXEC),
        .T_LONG    (T_LONG),
        .T_POWERUP (T_POWERUP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1),
        .in1_stb  (in1_stb),
        .in1_ack  (in1_ack),
        .lcd_data (lcd_data),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        logic       last;
        int         gap;   // E-low, busy cycles from this nibble's E fall until busy drops
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   sent = 0;
    int   ack_total = 0;

    int   phase = 0;       // 0 idle, 1 between nibbles, 2 in wait, 3 E high
    logic prev_e = 1'b0;
    logic [4:0] prev_bus = '0;
    int   hi_cnt = 0, lo_cnt = 0, w_cnt = 0, cur_gap = 0;
    logic cur_last = 1'b0;
    logic pw_armed = 1'b0;
    int   pw_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a word becomes one or two nibbles and a post-pulse wait
    task automatic push_word(input logic [9:0] w);
        exp_t e;
        logic [7:0] b;
        int wt;
        b  = w[7:0];
        wt = (!w[8] && !w[9] && b >= 8'd1 && b <= 8'd3) ? T_LONG : T_EXEC;
        e.rs   = w[8];
        e.nib  = b[7:4];
        e.last = w[9];
        e.gap  = T_E_LOW + wt;
        expq.push_back(e);
        if (!w[9]) begin
            e.nib  = b[3:0];
            e.last = 1'b1;
            e.gap  = wt;
            expq.push_back(e);
        end
    endtask

    task automatic push_rom();
        logic [9:0] rom [8];
        rom = '{10'h230, 10'h230, 10'h230, 10'h220, 10'h028, 10'h00C, 10'h001, 10'h006};
        for (int i = 0; i < 8; i++) push_word(rom[i]);
    endtask

    // Called at posedge+1; returns at posedge+1 after the acknowledging cycle
    task automatic send_word(input logic [9:0] w, input bit keep);
        int n;
        logic got;
        in1      = $urandom();
        in1[9:0] = w;
        in1_stb  = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < BOUND) begin
            @(negedge clk);
            n++;
            got = in1_ack;
        end
        if (got) begin
            push_word(w);
            sent++;
        end else begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: word %h not acknowledged within %0d cycles", w, BOUND);
        end
        @(posedge clk);
        #1;
        if (!keep) in1_stb = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(phase == 0 && !busy && expq.size() == 0) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0d queued=%0d, expected idle", busy, expq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rises(input int cnt);
        int n, seen;
        logic pe;
        n = 0; seen = 0; pe = lcd_e;
        while (seen < cnt && n < BOUND) begin
            @(negedge clk);
            n++;
            if (lcd_e && !pe) seen++;
            pe = lcd_e;
        end
        if (seen < cnt) begin
            checks++;
            errors++;
            $display("FAIL e_rise_timeout: saw %0d E pulses, expected %0d", seen, cnt);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lcd_e"},    lcd_e,    0);
        check({tag, "_lcd_data"}, lcd_data, 0);
        check({tag, "_lcd_rs"},   lcd_rs,   0);
        check({tag, "_in1_ack"},  in1_ack,  0);
        check({tag, "_busy"},     busy,     RST_BUSY);
    endtask

    // Bus monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            expq.delete();
            phase    = 0;
            prev_e   = 1'b0;
            pw_armed = 1'b1;
            pw_cnt   = 0;
        end else begin
            if (in1_ack) begin
                ack_total++;
                check("ack_only_when_idle", busy, 0);
            end
            if (in1_stb && !busy) check("ack_first_idle_cycle", in1_ack, 1);

            if (lcd_e && !prev_e) begin
`ifdef LCD_POWERUP_INIT_EN
                if (pw_armed) check("powerup_quiet_cycles", pw_cnt, T_POWERUP + T_SETUP);
`endif
                pw_armed = 1'b0;
                if (phase == 1) check("e_low_between_nibbles", lo_cnt, T_E_LOW + T_SETUP);
                else if (phase == 2) check("wait_then_next_word", w_cnt, cur_gap + T_SETUP);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_e_pulse: data=%h rs=%0d with nothing queued", lcd_data, lcd_rs);
                    cur_last = 1'b1;
                    cur_gap  = 0;
                end else begin
                    e = expq.pop_front();
                    check("nibble_rs", lcd_rs, e.rs);
                    check("nibble_data", lcd_data, e.nib);
                    cur_last = e.last;
                    cur_gap  = e.gap;
                end
                hi_cnt = 1;
                phase  = 3;
            end else if (lcd_e && prev_e) begin
                hi_cnt++;
                check("bus_stable_while_e_high", {lcd_rs, lcd_data}, prev_bus);
            end else if (!lcd_e && prev_e) begin
                check("e_high_cycles", hi_cnt, T_E_HIGH);
                if (cur_last) begin phase = 2; w_cnt = 1; end
                else begin phase = 1; lo_cnt = 1; end
            end else begin
                if (pw_armed) pw_cnt++;
                if (phase == 1) lo_cnt++;
                else if (phase == 2) begin
                    if (busy) w_cnt++;
                    else begin
                        check("wait_cycles", w_cnt, cur_gap);
                        phase = 0;
                    end
                end
            end
            prev_e   = lcd_e;
            prev_bus = {lcd_rs, lcd_data};
        end
    end

    initial begin
        #(60000 * 20);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] w;
        logic [7:0] b;
        int sel;
        rst     = 1'b1;
        in1     = '0;
        in1_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
`ifdef LCD_POWERUP_INIT_EN
        push_rom();
`endif

        // Directed: 'H' with rs, nibble-only, clear, 0x00
        send_word(10'h148, 1'b0);
        wait_idle();
        send_word(10'h230, 1'b0);
        wait_idle();
        send_word(10'h001, 1'b0);
        wait_idle();
        send_word(10'h000, 1'b0);
        wait_idle();

        // Three words back to back with stb held
        send_word(10'h141, 1'b1);
        send_word(10'h003, 1'b1);
        send_word(10'h27A, 1'b0);
        wait_idle();

        // Reset while the low nibble's E is high
        send_word(10'h155, 1'b0);
        wait_rises(2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midop_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef LCD_POWERUP_INIT_EN
        push_rom();
`endif
        send_word(10'h14F, 1'b0);
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 5);
            b   = (sel < 4) ? 8'(sel) : 8'($urandom_range(0, 255));
            w   = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b};
            send_word(w, ($urandom_range(0, 2) == 0));
            if (!in1_stb) repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
        in1_stb = 1'b0;
        wait_idle();

        check("ack_pulse_count", ack_total, sent);
        check("scoreboard_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
